// File: rtl/ecc_op_monitor_if.sv
// Bundle of APB control and DUT/golden-model result signals watched by ecc_op_monitor.
// The master side drives everything; the monitor only observes.
interface ecc_op_monitor_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       data_out;
  logic                       operation_done;
  logic [1:0]                 num_of_errors;
  logic [AMBA_WORD-1:0]       gm_data_out;
  logic [1:0]                 gm_num_of_errors;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE,
    output data_out, operation_done, num_of_errors,
    output gm_data_out, gm_num_of_errors
  );

  modport slave (
    input PADDR, PSEL, PENABLE, PWRITE,
    input data_out, operation_done, num_of_errors,
    input gm_data_out, gm_num_of_errors
  );
endinterface

// File: rtl/ecc_op_monitor.sv
// Watches ECC operations started by an APB control write and checks each result
// against a golden model; keeps sticky error flags, saturating counters and latency.
module ecc_op_monitor #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_LATENCY     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  ecc_op_monitor_if.slave                    bus,
  input  logic                               clear,
  output logic                               busy,
  output logic                               err_timeout,
  output logic                               err_data,
  output logic                               err_nerr,
  output logic                               err_spurious,
  output logic                               err_overlap,
  output logic                               err_pulse,
  output logic [CNT_WIDTH-1:0]               op_count,
  output logic [CNT_WIDTH-1:0]               fail_count,
  output logic [$clog2(MAX_LATENCY+1)-1:0]   last_latency
);
  localparam int LAT_W = $clog2(MAX_LATENCY + 1);
  localparam logic [LAT_W-1:0]     LAT_MAX = LAT_W'(MAX_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t            state_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;

  logic [AMBA_WORD-1:0] dut_word;
  logic [AMBA_WORD-1:0] gm_word;
  logic                 start;
  logic                 done;
  logic                 in_wait;
  logic                 ev_complete;
  logic                 ev_timeout;
  logic                 ev_overlap;
  logic                 ev_spurious;
  logic                 ev_data;
  logic                 ev_nerr;
  logic                 ev_any;
  logic [LAT_W:0]       lat_inc;
  logic [LAT_W-1:0]     lat_done;
  logic                 unused_bits;

  assign dut_word    = bus.data_out;
  assign gm_word     = bus.gm_data_out;
  // Upper address bits and data bits above DATA_WIDTH are intentionally ignored.
  assign unused_bits = ^{bus.PADDR[AMBA_ADDR_WIDTH-1:4], dut_word, gm_word};

  assign start   = bus.PSEL & bus.PENABLE & bus.PWRITE & (bus.PADDR[3:0] == 4'd0);
  assign done    = bus.operation_done;
  assign in_wait = (state_reg == WAIT_DONE);

  assign ev_complete = in_wait & done;
  assign ev_timeout  = in_wait & ~done & (lat_cnt_reg == LAT_MAX);
  // A start landing on the timeout cycle just launches the next op; the timeout is the error.
  assign ev_overlap  = in_wait & ~done & start & ~ev_timeout;
  assign ev_spurious = ~in_wait & done & ~start;
  assign ev_data     = ev_complete & (bus.num_of_errors != 2'd2) &
                       (dut_word[DATA_WIDTH-1:0] != gm_word[DATA_WIDTH-1:0]);
  assign ev_nerr     = ev_complete & (bus.num_of_errors != bus.gm_num_of_errors);
  assign ev_any      = ev_timeout | ev_overlap | ev_spurious | ev_data | ev_nerr;

  assign lat_inc  = {1'b0, lat_cnt_reg} + (LAT_W+1)'(1);
  assign lat_done = lat_inc[LAT_W] ? '1 : lat_inc[LAT_W-1:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lat_cnt_reg  <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      err_data     <= 1'b0;
      err_nerr     <= 1'b0;
      err_spurious <= 1'b0;
      err_overlap  <= 1'b0;
      err_pulse    <= 1'b0;
      op_count     <= '0;
      fail_count   <= '0;
      last_latency <= '0;
    end else begin
      err_pulse <= ev_any;
      if (ev_timeout)  err_timeout  <= 1'b1;
      if (ev_data)     err_data     <= 1'b1;
      if (ev_nerr)     err_nerr     <= 1'b1;
      if (ev_spurious) err_spurious <= 1'b1;
      if (ev_overlap)  err_overlap  <= 1'b1;
      if (ev_any)      fail_count   <= sat_inc(fail_count);
      if (ev_complete) begin
        op_count     <= sat_inc(op_count);
        last_latency <= lat_done;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= WAIT_DONE;
            busy        <= 1'b1;
            lat_cnt_reg <= '0;
          end
        end
        WAIT_DONE: begin
          if (start) begin
            lat_cnt_reg <= '0;
          end else if (done || ev_timeout) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (lat_cnt_reg != LAT_MAX) begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase

      // Clear overrides every same-cycle flag/counter update but leaves the FSM alone.
      if (clear) begin
        err_timeout  <= 1'b0;
        err_data     <= 1'b0;
        err_nerr     <= 1'b0;
        err_spurious <= 1'b0;
        err_overlap  <= 1'b0;
        err_pulse    <= 1'b0;
        op_count     <= '0;
        fail_count   <= '0;
        last_latency <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ecc_op_monitor.sv
// Directed bench for ecc_op_monitor: a time-based reference model checked every cycle
// against a 16-bit-counter instance and a 2-bit-counter instance, plus literal spot checks.
module tb_ecc_op_monitor;
  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int MAXL = 8;
  localparam int LW   = $clog2(MAXL + 1);

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  ecc_op_monitor_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW)) bus ();

  logic          busy, e_to, e_da, e_ne, e_sp, e_ov, e_pu;
  logic [15:0]   opc, flc;
  logic [LW-1:0] lat;
  logic          busy_s, e_to_s, e_da_s, e_ne_s, e_sp_s, e_ov_s, e_pu_s;
  logic [1:0]    opc_s, flc_s;
  logic [LW-1:0] lat_s;

  ecc_op_monitor #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .DATA_WIDTH(DW),
                   .MAX_LATENCY(MAXL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .clear(clear), .busy(busy),
    .err_timeout(e_to), .err_data(e_da), .err_nerr(e_ne), .err_spurious(e_sp),
    .err_overlap(e_ov), .err_pulse(e_pu), .op_count(opc), .fail_count(flc),
    .last_latency(lat));

  ecc_op_monitor #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .DATA_WIDTH(DW),
                   .MAX_LATENCY(MAXL), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .bus(bus.slave), .clear(clear), .busy(busy_s),
    .err_timeout(e_to_s), .err_data(e_da_s), .err_nerr(e_ne_s), .err_spurious(e_sp_s),
    .err_overlap(e_ov_s), .err_pulse(e_pu_s), .op_count(opc_s), .fail_count(flc_s),
    .last_latency(lat_s));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an op is "outstanding since edge m_start"; its age in edges decides
  // latency and timeout (an op may still complete on edge MAXL+1, later than that is a timeout).
  bit         m_busy  = 1'b0;
  bit         m_pulse = 1'b0;
  logic [4:0] m_flags = '0;   // {timeout, data, nerr, spurious, overlap}
  int         m_start = 0, m_ops = 0, m_fails = 0, m_lat = 0, cyc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_pulse = 0; m_flags = '0; m_ops = 0; m_fails = 0; m_lat = 0;
    end else begin
      bit st, dn;
      logic [4:0] ev;
      int age;
      st  = bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR[3:0] == 4'd0);
      dn  = bus.operation_done;
      ev  = '0;
      age = cyc - m_start;
      if (m_busy) begin
        if (dn) begin
          m_ops++;
          m_lat = age;
          ev[3] = (bus.num_of_errors != 2'd2) && (bus.data_out != bus.gm_data_out);
          ev[2] = (bus.num_of_errors != bus.gm_num_of_errors);
          m_busy = st;
        end else if (age > MAXL) begin
          ev[4] = 1'b1;
          m_busy = st;
        end else if (st) begin
          ev[0] = 1'b1;
        end
        if (st) m_start = cyc;
      end else begin
        if (st) begin
          m_busy  = 1;
          m_start = cyc;
        end else if (dn) begin
          ev[1] = 1'b1;
        end
      end
      m_flags = m_flags | ev;
      m_pulse = (ev != 0);
      if (ev != 0) m_fails++;
      if (clear) begin
        m_flags = '0; m_pulse = 0; m_ops = 0; m_fails = 0; m_lat = 0;
      end
      cyc++;
    end
  end

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #3;
      check("busy", busy, m_busy);
      check("flags", {e_to, e_da, e_ne, e_sp, e_ov}, m_flags);
      check("err_pulse", e_pu, m_pulse);
      check("op_count", opc, sat(m_ops, 16));
      check("fail_count", flc, sat(m_fails, 16));
      check("last_latency", lat, m_lat);
      check("busy_w2", busy_s, m_busy);
      check("flags_w2", {e_to_s, e_da_s, e_ne_s, e_sp_s, e_ov_s}, m_flags);
      check("op_count_w2", opc_s, sat(m_ops, 2));
      check("fail_count_w2", flc_s, sat(m_fails, 2));
      check("last_latency_w2", lat_s, m_lat);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Setup then access phase; returns just after the access edge.
  task automatic apb_write(input logic [AW-1:0] addr, input bit with_done);
    bus.PADDR = addr; bus.PSEL = 1; bus.PWRITE = 1; bus.PENABLE = 0;
    tick();
    bus.PENABLE = 1;
    if (with_done) begin
      bus.data_out = 32'hCAFE_F00D; bus.gm_data_out = 32'hCAFE_F00D;
      bus.num_of_errors = 2'd0; bus.gm_num_of_errors = 2'd0;
      bus.operation_done = 1;
    end
    tick();
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.operation_done = 0;
  endtask

  // Completion lands wait_n+1 edges after the access edge, i.e. latency wait_n+1.
  task automatic finish_op(input int wait_n, input logic [31:0] d, input logic [31:0] g,
                           input logic [1:0] n, input logic [1:0] gn);
    repeat (wait_n) tick();
    bus.data_out = d; bus.gm_data_out = g;
    bus.num_of_errors = n; bus.gm_num_of_errors = gn;
    bus.operation_done = 1;
    tick();
    bus.operation_done = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  initial begin
    bus.PADDR = '0; bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    bus.data_out = '0; bus.gm_data_out = '0; bus.num_of_errors = '0;
    bus.gm_num_of_errors = '0; bus.operation_done = 0;
    #1 rst = 0;
    repeat (2) tick();
    check("reset_busy", busy, 0);
    check("reset_op_count", opc, 0);
    check("reset_flags", {e_to, e_da, e_ne, e_sp, e_ov, e_pu}, 0);
    rst = 1;
    tick();

    // Good op, done 3 cycles after the write
    apb_write(20'h0, 0);
    finish_op(2, 32'h1234_5678, 32'h1234_5678, 2'd1, 2'd1);
    $display("txn basic op: op_count=%0d latency=%0d", opc, lat);
    check("basic_op_count", opc, 1);
    check("basic_latency", lat, 3);
    check("basic_flags", {e_to, e_da, e_ne, e_sp, e_ov}, 0);
    check("basic_busy", busy, 0);

    // Timeout
    apb_write(20'h0, 0);
    repeat (8) tick();
    check("pre_timeout_busy", busy, 1);
    check("pre_timeout_flag", e_to, 0);
    tick();
    $display("txn timeout: err_timeout=%0d fail_count=%0d busy=%0d", e_to, flc, busy);
    check("timeout_flag", e_to, 1);
    check("timeout_pulse", e_pu, 1);
    check("timeout_fail_count", flc, 1);
    check("timeout_busy", busy, 0);
    tick();
    check("timeout_pulse_drop", e_pu, 0);
    do_clear();
    check("clear_op_count", opc, 0);
    check("clear_fail_count", flc, 0);
    check("clear_timeout", e_to, 0);

    // Non-control address does not start; address 0x10 does
    apb_write(20'h4, 0);
    check("nonctrl_no_start", busy, 0);
    apb_write(20'h10, 0);
    finish_op(1, 32'hAAAA_0000, 32'h5555_0000, 2'd2, 2'd2);
    $display("txn uncorrectable: err_data=%0d err_nerr=%0d", e_da, e_ne);
    check("uncorr_no_data_err", e_da, 0);
    check("uncorr_no_nerr", e_ne, 0);
    check("uncorr_latency", lat, 2);
    apb_write(20'h0, 0);
    finish_op(0, 32'h0000_0001, 32'h0000_0001, 2'd1, 2'd0);
    $display("txn nerr: err_nerr=%0d fail_count=%0d", e_ne, flc);
    check("nerr_flag", e_ne, 1);
    check("nerr_data_clean", e_da, 0);
    check("nerr_fail_count", flc, 1);
    apb_write(20'h0, 0);
    finish_op(3, 32'h0000_0001, 32'h0000_0002, 2'd0, 2'd1);
    $display("txn data+nerr: err_data=%0d fail_count=%0d", e_da, flc);
    check("data_flag", e_da, 1);
    check("double_err_fail_once", flc, 2);
    check("double_err_latency", lat, 4);
    apb_write(20'h0, 0);
    finish_op(8, 32'h77, 32'h77, 2'd0, 2'd0);
    $display("txn max latency: latency=%0d err_timeout=%0d", lat, e_to);
    check("maxlat_latency", lat, 9);
    check("maxlat_no_timeout", e_to, 0);
    check("maxlat_op_count", opc, 4);
    do_clear();

    // Spurious done, overlap, and start+done same cycle
    bus.operation_done = 1;
    tick();
    bus.operation_done = 0;
    $display("txn spurious: err_spurious=%0d", e_sp);
    check("spurious_flag", e_sp, 1);
    apb_write(20'h0, 0);
    tick();
    apb_write(20'h0, 0);
    $display("txn overlap: err_overlap=%0d busy=%0d", e_ov, busy);
    check("overlap_flag", e_ov, 1);
    check("overlap_fail_count", flc, 2);
    finish_op(2, 32'h5, 32'h5, 2'd0, 2'd0);
    check("overlap_restart_latency", lat, 3);
    apb_write(20'h0, 0);
    tick();
    apb_write(20'h0, 1);
    $display("txn done+start: op_count=%0d busy=%0d", opc, busy);
    check("backtoback_busy", busy, 1);
    check("backtoback_latency", lat, 3);
    check("backtoback_no_err", flc, 2);
    finish_op(0, 32'h9, 32'h9, 2'd0, 2'd0);
    check("backtoback_op_count", opc, 3);
    check("backtoback_latency2", lat, 1);
    do_clear();

    // Saturation of the 2-bit instance, then clear racing a completion
    for (int i = 0; i < 5; i++) begin
      apb_write(20'h0, 0);
      finish_op(1, 32'h3, 32'h3, 2'd0, 2'd0);
    end
    $display("txn saturate: op_count=%0d op_count_w2=%0d", opc, opc_s);
    check("sat_op_count", opc, 5);
    check("sat_op_count_w2", opc_s, 3);
    apb_write(20'h0, 0);
    tick();
    clear = 1;
    finish_op(0, 32'h3, 32'h3, 2'd0, 2'd0);
    clear = 0;
    check("clear_wins_op_count", opc, 0);
    check("clear_wins_w2", opc_s, 0);
    check("clear_wins_latency", lat, 0);
    check("clear_fsm_idle", busy, 0);

    // Reset in the middle of an op
    apb_write(20'h0, 0);
    finish_op(1, 32'h3, 32'h3, 2'd0, 2'd0);
    apb_write(20'h0, 0);
    repeat (2) tick();
    rst = 0;
    #1;
    $display("txn mid-op reset: busy=%0d op_count=%0d", busy, opc);
    check("rst_async_busy", busy, 0);
    check("rst_async_op_count", opc, 0);
    tick();
    rst = 1;
    repeat (12) tick();
    check("post_rst_no_timeout", e_to, 0);
    check("post_rst_fail_count", flc, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ecc_op_monitor.md
ECC_OP_MONITOR -- requirements
Module: ecc_op_monitor

Interface
REQ-001 Parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-002 Parameter AMBA_WORD, default 32, APB data width.
REQ-003 Parameter DATA_WIDTH, default 32, compared width of data_out/gm_data_out (DATA_WIDTH <= AMBA_WORD).
REQ-004 Parameter MAX_LATENCY, default 8, max cycles from control write to operation_done (>= 1).
REQ-005 Parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 PADDR  in  AMBA_ADDR_WIDTH  APB address.
REQ-009 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-010 data_out  in  AMBA_WORD  DUT result.
REQ-011 operation_done  in  1  DUT completion strobe.
REQ-012 num_of_errors  in  2  DUT error count (2 = uncorrectable).
REQ-013 gm_data_out  in  AMBA_WORD  golden-model result.
REQ-014 gm_num_of_errors  in  2  golden-model error count.
REQ-015 clear  in  1  synchronous clear of sticky flags and counters.
REQ-016 busy  out  1  operation outstanding.
REQ-017 err_timeout, err_data, err_nerr, err_spurious, err_overlap  out  1 each  sticky error flags.
REQ-018 err_pulse  out  1  one-cycle strobe on any new error event.
REQ-019 op_count, fail_count  out  CNT_WIDTH each  completed ops / ops with any error.
REQ-020 last_latency  out  $clog2(MAX_LATENCY+1)  cycles taken by last completed op.

Function
REQ-021 Start event = PSEL & PENABLE & PWRITE & (PADDR[3:0] == 0), sampled on rising clk.
REQ-022 FSM states IDLE, WAIT_DONE; IDLE --start--> WAIT_DONE, latency counter loaded with 0.
REQ-023 In WAIT_DONE counter increments by 1 per cycle, never exceeding MAX_LATENCY.
REQ-024 WAIT_DONE & operation_done: compare, last_latency <= counter+1, op_count += 1, go IDLE.
REQ-025 Data check: if num_of_errors != 2 and data_out[DATA_WIDTH-1:0] != gm_data_out[DATA_WIDTH-1:0], set err_data.
REQ-026 Error-count check: num_of_errors != gm_num_of_errors sets err_nerr (checked regardless of value 2).
REQ-027 WAIT_DONE with counter == MAX_LATENCY and no operation_done: set err_timeout, fail_count += 1, go IDLE.
REQ-028 operation_done while IDLE (and no start same cycle): set err_spurious, fail_count += 1.
REQ-029 Start while WAIT_DONE without operation_done: set err_overlap, fail_count += 1, counter restarts at 0, stay WAIT_DONE.
REQ-030 Start and operation_done same cycle in WAIT_DONE: complete current op per REQ-024, then enter WAIT_DONE with counter 0 (no overlap error).
REQ-031 fail_count increments at most once per op, even if err_data and err_nerr both set.
REQ-032 err_pulse high exactly one cycle for each cycle in which any error flag condition fires (even if flag already sticky).
REQ-033 Counters saturate at all-ones; no wrap.
REQ-034 busy = (state == WAIT_DONE), registered.
REQ-035 clear: zero all flags, counters, last_latency next edge; FSM state unaffected; clear wins over same-cycle increments.

Reset
REQ-036 On rst low, asynchronously: state IDLE, counter 0, all err_* 0, err_pulse 0, op_count 0, fail_count 0, last_latency 0, busy 0.
REQ-037 Reset mid-operation abandons it with no error recorded; first edge after release behaves as IDLE.

Verification
REQ-038 Write control (PADDR=0), operation_done 3 cycles later, data_out=gm=0x1234_5678, errors 1/1 -> op_count=1, last_latency=3, no flags.
REQ-039 Write control, no operation_done for MAX_LATENCY=8 cycles -> err_timeout=1, err_pulse one cycle, fail_count=1, busy=0.
REQ-040 Done with num_of_errors=2, gm=2, data_out!=gm_data_out -> no err_data, err_nerr=0; then num_of_errors=1, gm=0 -> err_nerr=1.
REQ-041 operation_done while IDLE -> err_spurious=1; second control write during WAIT_DONE -> err_overlap=1, counter restarts.
REQ-042 CNT_WIDTH=2, five good ops -> op_count holds 3; assert clear -> all zero next cycle.
REQ-043 rst low for one cycle during WAIT_DONE -> outputs zero immediately, no timeout afterward.
